// File: rtl/vec_issue_sequencer.sv
// Vector issue sequencer: splits one decoded vector instruction into LANES-wide
// element groups, issues them under an outstanding-writeback limit, then signals done.
module vec_issue_sequencer #(
  parameter int LANES      = 4,
  parameter int VLEN_ELEMS = 32,
  parameter int MAX_OUT    = 2,
  parameter int OP_W       = 6,
  localparam int VL_W      = $clog2(VLEN_ELEMS + 1),
  localparam int IDX_W     = $clog2(VLEN_ELEMS),
  localparam int OUT_W     = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [OP_W-1:0]  cmd_op_i,
  input  logic [4:0]       cmd_vs1_i,
  input  logic [4:0]       cmd_vs2_i,
  input  logic [4:0]       cmd_vd_i,
  input  logic [VL_W-1:0]  cmd_vl_i,
  output logic             iss_valid_o,
  input  logic             iss_ready_i,
  output logic [OP_W-1:0]  iss_op_o,
  output logic [4:0]       iss_vs1_o,
  output logic [4:0]       iss_vs2_o,
  output logic [4:0]       iss_vd_o,
  output logic [IDX_W-1:0] iss_elem_idx_o,
  output logic [LANES-1:0] iss_lane_en_o,
  output logic             iss_last_o,
  input  logic             wb_valid_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int CMP_W = VL_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [4:0]        vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
  logic [VL_W-1:0]   vl_q, vl_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              err_q, err_d;

  logic              hs;
  logic              wb_dec;
  logic              wb_err;
  logic [VL_W-1:0]   vl_clamp;
  logic [CMP_W-1:0]  idx_ext;
  logic [CMP_W-1:0]  vl_ext;

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign err_o       = err_q;

  assign iss_valid_o = (state_q == S_ISSUE) && (out_q < OUT_W'(MAX_OUT));
  assign hs          = iss_valid_o && iss_ready_i;
  assign wb_dec      = wb_valid_i && (state_q != S_IDLE);
  assign wb_err      = wb_valid_i && ((state_q == S_IDLE) || (out_q == '0));

  assign vl_clamp = (cmd_vl_i > VL_W'(VLEN_ELEMS)) ? VL_W'(VLEN_ELEMS) : cmd_vl_i;

  assign iss_op_o       = op_q;
  assign iss_vs1_o      = vs1_q;
  assign iss_vs2_o      = vs2_q;
  assign iss_vd_o       = vd_q;
  assign iss_elem_idx_o = idx_q;

  // One extra bit so idx + offset never wraps before the compare against vl.
  assign idx_ext = CMP_W'(idx_q);
  assign vl_ext  = CMP_W'(vl_q);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane_en
      assign iss_lane_en_o[gi] = (state_q == S_ISSUE) && ((idx_ext + CMP_W'(gi)) < vl_ext);
    end
  endgenerate

  assign iss_last_o = (state_q == S_ISSUE) && ((idx_ext + CMP_W'(LANES)) >= vl_ext);

  // Simultaneous issue and writeback cancel; a stray writeback never underflows.
  always_comb begin
    out_d = out_q;
    if (hs && !wb_dec) begin
      out_d = out_q + OUT_W'(1);
    end else if (!hs && wb_dec && (out_q != '0)) begin
      out_d = out_q - OUT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    vs1_d   = vs1_q;
    vs2_d   = vs2_q;
    vd_d    = vd_q;
    vl_d    = vl_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d    = cmd_op_i;
          vs1_d   = cmd_vs1_i;
          vs2_d   = cmd_vs2_i;
          vd_d    = cmd_vd_i;
          vl_d    = vl_clamp;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = (vl_clamp == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hs) begin
          if (iss_last_o) begin
            state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + IDX_W'(LANES);
          end
        end
      end
      S_DRAIN: begin
        if (out_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (wb_err) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      vd_q    <= '0;
      vl_q    <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vs1_q   <= vs1_d;
      vs2_q   <= vs2_d;
      vd_q    <= vd_d;
      vl_q    <= vl_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

endmodule
